// File: rtl/fpu_pkg.sv
// Shared floating-point unit constants and the in-flight tracking record used
// by the fmul arbiter. Requester ids are stored at the widest supported size
// (up to 8 requesters) so the record layout does not depend on NREQ.
package fpu_pkg;

  // IEEE-754 single-precision word width
  localparam int FP_W = 32;

  // Default pipeline depth of the shared fmul: operands to y
  localparam int FMUL_LAT = 2;

  // Largest supported requester count and the id width that covers it
  localparam int MAX_NREQ = 8;
  localparam int ID_W     = 3;

  // One slot of the in-flight shift register
  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } infl_t;

  // Empty slot, used on reset and for idle cycles
  localparam infl_t INFL_IDLE = '{vld: 1'b0, id: '0};

  // Build a slot from a grant strobe and the granted index
  function automatic infl_t mk_infl(input logic vld, input logic [ID_W-1:0] id);
    infl_t s;
    s.vld = vld;
    s.id  = vld ? id : '0;
    return s;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant over N requesters. The search starts at
// the priority pointer; after a grant the pointer moves one past the winner
// so the winner becomes lowest priority. With no grant the pointer holds.
module rr_arbiter
  import fpu_pkg::*;
#(
  parameter int N = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    i_req,
  output logic [N-1:0]    o_gnt,
  output logic [ID_W-1:0] o_gnt_idx,
  output logic            o_any
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [N-1:0]  w_hi;
  logic [N-1:0]  w_pick;
  logic [N-1:0]  w_gnt;
  logic [ID_W-1:0] w_idx;
  logic [PW-1:0] w_nxt;
  logic          w_any;

  // Requests at or above the pointer win first; otherwise wrap to the bottom
  always_comb begin
    w_hi  = '0;
    w_gnt = '0;
    w_idx = '0;
    w_nxt = r_ptr;
    w_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_hi[i] = i_req[i] && (i >= int'(r_ptr));
    end
    w_pick = (|w_hi) ? w_hi : i_req;
    for (int i = 0; i < N; i++) begin
      if (!w_any && w_pick[i]) begin
        w_any    = 1'b1;
        w_gnt[i] = 1'b1;
        w_idx    = ID_W'(i);
        w_nxt    = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  // Priority pointer: advance past the winner on each grant
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= w_nxt;
    end
  end

  assign o_gnt     = w_gnt;
  assign o_gnt_idx = w_idx;
  assign o_any     = w_any;

endmodule

// File: rtl/fmul_arb.sv
// fmul_arb: shares one pipelined fmul among NREQ requesters.
// A round-robin grant selects one requester per cycle; its operands go to the
// fmul in the same cycle. A LAT+1 deep shift register of {valid, id} follows
// each operation so the registered result is steered back to its owner
// exactly LAT+1 cycles after the handshake, in issue order.
// Optional feature: define FMUL_ARB_OVF_STICKY_EN to enable per-requester
// sticky overflow flags (otherwise ovf_sticky is tied low and ovf_clr unused).
module fmul_arb
  import fpu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LAT  = FMUL_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [FP_W*NREQ-1:0] req_x1,
  input  logic [FP_W*NREQ-1:0] req_x2,
  output logic [NREQ-1:0]      req_ready,
  output logic [FP_W-1:0]      mul_x1,
  output logic [FP_W-1:0]      mul_x2,
  input  logic [FP_W-1:0]      mul_y,
  input  logic                 mul_ovf,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [FP_W-1:0]      rsp_y,
  output logic                 rsp_ovf,
  input  logic [NREQ-1:0]      ovf_clr,
  output logic [NREQ-1:0]      ovf_sticky
);

  logic [NREQ-1:0] w_req;
  logic [NREQ-1:0] w_gnt;
  logic [ID_W-1:0] w_gnt_idx;
  logic            w_any;
  logic [FP_W-1:0] w_x1;
  logic [FP_W-1:0] w_x2;
  logic [NREQ-1:0] w_rsp_vld;

  infl_t           r_infl_p [LAT+1];
  logic            r_ovf_p1;
  logic [FP_W-1:0] r_rsp_y;
  logic            r_rsp_ovf;

  // Nothing is granted while reset is asserted
  assign w_req = req_valid & {NREQ{~rst}};

  rr_arbiter #(
    .N (NREQ)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (w_req),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  assign req_ready = w_gnt;

  // Stage p0: operand mux to the fmul, zero when idle
  always_comb begin
    w_x1 = '0;
    w_x2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_x1 = req_x1[FP_W*i +: FP_W];
        w_x2 = req_x2[FP_W*i +: FP_W];
      end
    end
  end

  assign mul_x1 = w_x1;
  assign mul_x2 = w_x2;

  // In-flight tracker: slot k describes the issue from k+1 cycles ago
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= LAT; k++) begin
        r_infl_p[k] <= INFL_IDLE;
      end
    end else begin
      r_infl_p[0] <= mk_infl(w_any, w_gnt_idx);
      for (int k = 1; k <= LAT; k++) begin
        r_infl_p[k] <= r_infl_p[k-1];
      end
    end
  end

  // Stage p1: overflow arrives one cycle ahead of y, delay it to line up
  always_ff @(posedge clk) begin
    r_ovf_p1 <= mul_ovf;
  end

  // Stage p2: capture y and its overflow when the tracked op reaches the fmul output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_y   <= '0;
      r_rsp_ovf <= 1'b0;
    end else if (r_infl_p[LAT-1].vld) begin
      r_rsp_y   <= mul_y;
      r_rsp_ovf <= r_ovf_p1;
    end
  end

  assign rsp_y   = r_rsp_y;
  assign rsp_ovf = r_rsp_ovf;

  // Result strobe: decode the owner id of the oldest tracker slot
  always_comb begin
    w_rsp_vld = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_rsp_vld[i] = r_infl_p[LAT].vld && (r_infl_p[LAT].id == ID_W'(i));
    end
  end

  assign rsp_valid = w_rsp_vld;

`ifdef FMUL_ARB_OVF_STICKY_EN
  logic [NREQ-1:0] r_sticky;

  // Sticky overflow: a new overflow outranks a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= (r_sticky & ~ovf_clr) | (w_rsp_vld & {NREQ{r_rsp_ovf}});
    end
  end

  assign ovf_sticky = r_sticky;
`else
  logic w_ovf_clr_unused;

  assign w_ovf_clr_unused = ^ovf_clr;
  assign ovf_sticky       = '0;
`endif

endmodule

// File: tb/tb_fmul_arb.sv
// Testbench for fmul_arb (NREQ=2, LAT=2). A behavioural fmul with the same
// latency sits on the mul_* port pair. A reference model (round-robin pointer,
// queue of expected results with due cycle, sticky bits) is compared against
// the DUT every cycle; scenario tasks add directed checks.
module tb_fmul_arb;

  localparam int NREQ = 2;
  localparam int LAT  = 2;
`ifdef FMUL_ARB_OVF_STICKY_EN
  localparam logic STK_ON = 1'b1;
`else
  localparam logic STK_ON = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [32*NREQ-1:0]  req_x1;
  logic [32*NREQ-1:0]  req_x2;
  logic [NREQ-1:0]     req_ready;
  logic [31:0]         mul_x1;
  logic [31:0]         mul_x2;
  logic [31:0]         mul_y;
  logic                mul_ovf;
  logic [NREQ-1:0]     rsp_valid;
  logic [31:0]         rsp_y;
  logic                rsp_ovf;
  logic [NREQ-1:0]     ovf_clr;
  logic [NREQ-1:0]     ovf_sticky;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fmul_arb #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_x1     (req_x1),
    .req_x2     (req_x2),
    .req_ready  (req_ready),
    .mul_x1     (mul_x1),
    .mul_x2     (mul_x2),
    .mul_y      (mul_y),
    .mul_ovf    (mul_ovf),
    .rsp_valid  (rsp_valid),
    .rsp_y      (rsp_y),
    .rsp_ovf    (rsp_ovf),
    .ovf_clr    (ovf_clr),
    .ovf_sticky (ovf_sticky)
  );

  // Simplified float multiply (truncating, flush-to-zero); returns {ovf, y}
  function automatic logic [32:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          ea, eb, e;
    logic [47:0] p;
    logic [22:0] m;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0 || eb == 0) return {1'b0, s, 31'h0};
    p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    e = ea + eb - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {1'b1, s, 8'hFF, 23'h0};
    if (e <= 0) return {1'b0, s, 31'h0};
    return {1'b0, s, e[7:0], m};
  endfunction

  // Behavioural fmul: y after LAT cycles, ovf one cycle earlier
  logic [31:0] fm_y_p [LAT];
  logic        fm_o_p [LAT];
  logic [32:0] fm_r;
  always @(posedge clk) begin
    fm_r = fmul_ref(mul_x1, mul_x2);
    fm_y_p[0] <= fm_r[31:0];
    fm_o_p[0] <= fm_r[32];
    for (int k = 1; k < LAT; k++) begin
      fm_y_p[k] <= fm_y_p[k-1];
      fm_o_p[k] <= fm_o_p[k-1];
    end
  end
  assign mul_y   = fm_y_p[LAT-1];
  assign mul_ovf = fm_o_p[LAT-2];

  // Reference model state
  typedef struct {
    int          due;
    int          id;
    logic [31:0] y;
    logic        ovf;
  } exp_t;

  exp_t            q[$];
  exp_t            cur;
  int              ncyc = 0;
  int              m_ptr = 0;
  logic [NREQ-1:0] m_sticky = '0;
  logic [31:0]     m_y = '0;
  logic            m_ovf = 1'b0;
  bit              mon_en = 1'b0;
  int              gi;
  bit              due_hit;
  logic [NREQ-1:0] eg, erv, eset;
  logic [31:0]     ex1, ex2;
  logic [32:0]     er;

  always @(negedge clk) begin
    gi = -1;
    if (!rst) begin
      for (int k = 0; k < NREQ; k++) begin
        if (gi < 0 && req_valid[(m_ptr + k) % NREQ]) gi = (m_ptr + k) % NREQ;
      end
    end
    eg = '0; ex1 = '0; ex2 = '0;
    if (gi >= 0) begin
      eg[gi] = 1'b1;
      ex1 = req_x1[32*gi +: 32];
      ex2 = req_x2[32*gi +: 32];
    end
    due_hit = (q.size() > 0) && (q[0].due == ncyc);
    erv = '0;
    if (due_hit) erv[q[0].id] = 1'b1;
    if (mon_en) begin
      n_checks++;
      if (req_ready !== eg) begin n_errors++; $display("FAIL mon_ready cyc=%0d got %b want %b", ncyc, req_ready, eg); end
      n_checks++;
      if (mul_x1 !== ex1 || mul_x2 !== ex2) begin n_errors++; $display("FAIL mon_operands cyc=%0d got %h/%h want %h/%h", ncyc, mul_x1, mul_x2, ex1, ex2); end
      n_checks++;
      if (rsp_valid !== erv) begin n_errors++; $display("FAIL mon_rsp_valid cyc=%0d got %b want %b", ncyc, rsp_valid, erv); end
      n_checks++;
      if (due_hit) begin
        if (rsp_y !== q[0].y || rsp_ovf !== q[0].ovf) begin n_errors++; $display("FAIL mon_rsp_data cyc=%0d got %h/%b want %h/%b", ncyc, rsp_y, rsp_ovf, q[0].y, q[0].ovf); end
      end else begin
        if (rsp_y !== m_y || rsp_ovf !== m_ovf) begin n_errors++; $display("FAIL mon_rsp_hold cyc=%0d got %h/%b want %h/%b", ncyc, rsp_y, rsp_ovf, m_y, m_ovf); end
      end
      n_checks++;
      if (ovf_sticky !== m_sticky) begin n_errors++; $display("FAIL mon_sticky cyc=%0d got %b want %b", ncyc, ovf_sticky, m_sticky); end
    end
    // advance the model to the state after the next rising edge
    if (due_hit) cur = q.pop_front();
    if (rst) begin
      q.delete();
      m_ptr = 0; m_sticky = '0; m_y = '0; m_ovf = 1'b0;
    end else begin
      eset = '0;
      if (due_hit) begin
        m_y = cur.y; m_ovf = cur.ovf;
        if (cur.ovf) eset[cur.id] = 1'b1;
      end
      if (STK_ON) m_sticky = (m_sticky & ~ovf_clr) | eset;
      if (gi >= 0) begin
        er = fmul_ref(ex1, ex2);
        q.push_back('{due: ncyc + LAT + 1, id: gi, y: er[31:0], ovf: er[32]});
        m_ptr = (gi + 1) % NREQ;
      end
    end
    ncyc++;
  end

  function automatic logic [31:0] rnd_fp();
    logic [7:0] e;
    e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(200, 254)) : 8'($urandom_range(100, 150));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; req_valid = '0; ovf_clr = '0;
  endtask

  task automatic rnd_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_x1[32*i +: 32] = rnd_fp();
      req_x2[32*i +: 32] = rnd_fp();
    end
  endtask

  task automatic rst_pulse();
    idle(); rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; ovf_clr = '0; rnd_ops();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== 2'b00) begin n_errors++; $display("FAIL reset_ready got %b want 00", req_ready); end
      n_checks++;
      if (rsp_valid !== 2'b00 || rsp_y !== 32'h0 || rsp_ovf !== 1'b0) begin n_errors++; $display("FAIL reset_rsp got %b/%h/%b want 00/0/0", rsp_valid, rsp_y, rsp_ovf); end
      n_checks++;
      if (ovf_sticky !== 2'b00 || mul_x1 !== 32'h0) begin n_errors++; $display("FAIL reset_misc got %b/%h want 00/0", ovf_sticky, mul_x1); end
      tick();
    end
    mon_en = 1'b1;
    idle();
    tick();
  endtask

  task automatic test_single();
    idle(); rnd_ops();
    req_valid = 2'b01;
    req_x1[31:0] = 32'h3F800000;
    req_x2[31:0] = 32'h40000000;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b01 || mul_x1 !== 32'h3F800000 || mul_x2 !== 32'h40000000) begin n_errors++; $display("FAIL single_issue got %b/%h/%h want 01/3f800000/40000000", req_ready, mul_x1, mul_x2); end
    tick(); req_valid = '0;
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 2'b00) begin n_errors++; $display("FAIL single_early got %b want 00", rsp_valid); end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 2'b01 || rsp_y !== 32'h40000000 || rsp_ovf !== 1'b0) begin n_errors++; $display("FAIL single_rsp got %b/%h/%b want 01/40000000/0", rsp_valid, rsp_y, rsp_ovf); end
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] e;
    rst_pulse(); rnd_ops();
    req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) req_valid = '0;
      @(negedge clk);
      if (k < 4) begin
        e = (k % 2 == 1) ? 2'b10 : 2'b01;
        n_checks++;
        if (req_ready !== e) begin n_errors++; $display("FAIL contention_grant k=%0d got %b want %b", k, req_ready, e); end
      end
      e = (k >= 3 && k <= 6) ? (((k - 3) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      n_checks++;
      if (rsp_valid !== e) begin n_errors++; $display("FAIL contention_rsp k=%0d got %b want %b", k, rsp_valid, e); end
      tick();
    end
  endtask

  task automatic test_overflow();
    rst_pulse(); rnd_ops();
    req_valid = 2'b10;
    req_x1[63:32] = 32'h7F000000;
    req_x2[63:32] = 32'h7F000000;
    tick(); req_valid = '0;
    tick(); tick();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 2'b10 || rsp_ovf !== 1'b1 || rsp_y !== 32'h7F800000) begin n_errors++; $display("FAIL ovf_rsp got %b/%b/%h want 10/1/7f800000", rsp_valid, rsp_ovf, rsp_y); end
    tick();
    @(negedge clk);
    n_checks++;
    if (ovf_sticky !== {STK_ON, 1'b0}) begin n_errors++; $display("FAIL ovf_sticky_set got %b want %b", ovf_sticky, {STK_ON, 1'b0}); end
    ovf_clr = 2'b10;
    tick(); ovf_clr = '0;
    @(negedge clk);
    n_checks++;
    if (ovf_sticky !== 2'b00) begin n_errors++; $display("FAIL ovf_sticky_clr got %b want 00", ovf_sticky); end
    tick();
  endtask

  task automatic test_collision();
    rst_pulse(); rnd_ops();
    req_valid = 2'b01;
    req_x1[31:0] = 32'h7F000000;
    req_x2[31:0] = 32'h7F000000;
    tick(); req_valid = '0;
    tick(); tick();
    ovf_clr = 2'b01;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 2'b01 || rsp_ovf !== 1'b1) begin n_errors++; $display("FAIL collide_rsp got %b/%b want 01/1", rsp_valid, rsp_ovf); end
    tick(); ovf_clr = '0;
    @(negedge clk);
    n_checks++;
    if (ovf_sticky[0] !== STK_ON) begin n_errors++; $display("FAIL collide_sticky got %b want %b", ovf_sticky[0], STK_ON); end
    ovf_clr = 2'b01;
    tick(); ovf_clr = '0;
  endtask

  task automatic test_reset_midflight();
    idle(); rnd_ops();
    req_valid = 2'b01;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b01) begin n_errors++; $display("FAIL midrst_issue got %b want 01", req_ready); end
    tick();
    rst = 1'b1; req_valid = 2'b11;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b00) begin n_errors++; $display("FAIL midrst_ready got %b want 00", req_ready); end
    tick();
    idle();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 2'b00) begin n_errors++; $display("FAIL midrst_rsp k=%0d got %b want 00", k, rsp_valid); end
      tick();
    end
    req_valid = 2'b11;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b01) begin n_errors++; $display("FAIL midrst_ptr got %b want 01", req_ready); end
    tick(); idle();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst       = ($urandom_range(0, 39) == 0);
      req_valid = 2'($urandom);
      ovf_clr   = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      rnd_ops();
      @(negedge clk);
      n_checks++;
      if ($countones(rsp_valid) > 1 || $countones(req_ready) > 1) begin n_errors++; $display("FAIL random_onehot k=%0d got %b/%b want at most one bit each", k, rsp_valid, req_ready); end
      tick();
    end
    idle();
    repeat (LAT + 3) tick();
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; ovf_clr = '0; req_x1 = '0; req_x2 = '0;
    test_reset();
    test_single();
    test_contention();
    test_overflow();
    test_collision();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
